flight_cntrl: RTL and testbench

Quadcopter PD attitude controller. Compares measured pitch/roll/yaw against desired values and forms a proportional term and a derivative term per axis. Mixes these with the thrust command into four saturated 11-bit motor speed commands. Sits between the inertial integrator (attitude, `vld`) and the ESC interface.

---
 rtl/flight_cntrl_pkg.sv | 14 +
 rtl/flight_cntrl_pd_axis.sv | 35 +++
 rtl/flight_cntrl.sv | 61 ++++++
 tb/tb_flight_cntrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/flight_cntrl_pkg.sv
// flght_pkg: shared constants and saturation helper for the attitude controller.
package flght_pkg;
  localparam logic [12:0] MIN_RUN_SPEED = 13'h2C0;
  localparam logic [10:0] CAL_SPEED = 11'h1B0;
  localparam logic signed [9:0] D_MULT = 10'sd7;
  localparam int unsigned ERR_W = 10;
  localparam int unsigned D_SAT_W = 7;
  function automatic logic signed [16:0] sat_signed(input logic signed [16:0] v, input int unsigned w);
    logic signed [16:0] hi, lo;
    hi = (17'sd1 <<< (w - 1)) - 17'sd1;
    lo = -(17'sd1 <<< (w - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/flight_cntrl_pd_axis.sv
// pd_axis: per-axis saturated error, P term and D term over a sample history queue.
module pd_axis
  import flght_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld_i,
  input  logic signed [15:0] meas_i,
  input  logic signed [15:0] desired_i,
  output logic signed [9:0]  p_o,
  output logic signed [9:0]  d_o
);
  logic signed [16:0] err;
  logic signed [9:0] err_sat;
  logic signed [10:0] diff;
  logic signed [6:0] d_sat;
  logic signed [9:0] q_q [D_QUEUE_DEPTH];
  assign err = 17'(meas_i) - 17'(desired_i);
  assign err_sat = 10'(sat_signed(err, ERR_W));
  assign p_o = (err_sat >>> 1) + (err_sat >>> 3);
  // q_q[0] is the oldest sample; the difference uses it before this edge's shift
  assign diff = 11'(err_sat) - 11'(q_q[0]);
  assign d_sat = 7'(sat_signed(17'(diff), D_SAT_W));
  assign d_o = 10'(d_sat) * D_MULT;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < D_QUEUE_DEPTH; i++) q_q[i] <= '0;
    end else if (vld_i) begin
      for (int i = 0; i < D_QUEUE_DEPTH - 1; i++) q_q[i] <= q_q[i + 1];
      q_q[D_QUEUE_DEPTH - 1] <= err_sat;
    end
  end
endmodule

// File: rtl/flight_cntrl.sv
// flight_cntrl: PD attitude controller mixing three axes and thrust into four motor speeds.
module flight_cntrl
  import flght_pkg::*;
#(
  parameter int D_QUEUE_DEPTH = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic               inertial_cal,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic [8:0]         thrst,
  output logic [10:0]        frnt_spd,
  output logic [10:0]        bck_spd,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rght_spd
);
  logic signed [9:0] p_p, d_p, p_r, d_r, p_y, d_y;
  logic signed [12:0] base, pt, rt, yt;
  logic [10:0] frnt_d, bck_d, lft_d, rght_d;
  function automatic logic [10:0] sat_out(input logic signed [12:0] v);
    return (v < 13'sd0) ? 11'd0 : (v > 13'sd2047) ? 11'd2047 : v[10:0];
  endfunction
  pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_ptch (
    .clk(clk), .rst_n(rst_n), .vld_i(vld), .meas_i(ptch), .desired_i(d_ptch), .p_o(p_p), .d_o(d_p)
  );
  pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_roll (
    .clk(clk), .rst_n(rst_n), .vld_i(vld), .meas_i(roll), .desired_i(d_roll), .p_o(p_r), .d_o(d_r)
  );
  pd_axis #(.D_QUEUE_DEPTH(D_QUEUE_DEPTH)) u_yaw (
    .clk(clk), .rst_n(rst_n), .vld_i(vld), .meas_i(yaw), .desired_i(d_yaw), .p_o(p_y), .d_o(d_y)
  );
  assign base = $signed(MIN_RUN_SPEED + {4'b0, thrst});
  assign pt = 13'(p_p) + 13'(d_p);
  assign rt = 13'(p_r) + 13'(d_r);
  assign yt = 13'(p_y) + 13'(d_y);
  always_comb begin
    frnt_d = inertial_cal ? CAL_SPEED : sat_out(base - pt - yt);
    bck_d = inertial_cal ? CAL_SPEED : sat_out(base + pt - yt);
    lft_d = inertial_cal ? CAL_SPEED : sat_out(base - rt + yt);
    rght_d = inertial_cal ? CAL_SPEED : sat_out(base + rt + yt);
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      frnt_spd <= '0;
      bck_spd <= '0;
      lft_spd <= '0;
      rght_spd <= '0;
    end else begin
      frnt_spd <= frnt_d;
      bck_spd <= bck_d;
      lft_spd <= lft_d;
      rght_spd <= rght_d;
    end
  end
endmodule

// File: tb/tb_flight_cntrl.sv
// tb_flight_cntrl: directed and random stimulus against a queue-based reference model.
module tb_flight_cntrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0;
  logic cal = 1'b0;
  logic signed [15:0] m [3];
  logic signed [15:0] d [3];
  logic [8:0] thrst = '0;
  logic [10:0] frnt, bck, lft, rght;
  int total = 0;
  int bad = 0;
  int hist [3][$];
  int ex [4];

  always #5 clk = ~clk;

  flight_cntrl #(.D_QUEUE_DEPTH(14)) dut (
    .clk(clk), .rst_n(rst), .vld(vld), .inertial_cal(cal),
    .d_ptch(d[0]), .d_roll(d[1]), .d_yaw(d[2]),
    .ptch(m[0]), .roll(m[1]), .yaw(m[2]),
    .thrst(thrst),
    .frnt_spd(frnt), .bck_spd(bck), .lft_spd(lft), .rght_spd(rght)
  );

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic logic signed [15:0] rnd_ang();
    return ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 600)) - 300);
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input int want);
    total++;
    assert (got === 11'(want)) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic apply();
    int e, tot [3], b;
    if (rst) begin
      ex = '{0, 0, 0, 0};
      for (int a = 0; a < 3; a++) begin
        hist[a] = {};
        repeat (14) hist[a].push_back(0);
      end
    end else begin
      for (int a = 0; a < 3; a++) begin
        e = clamp(int'(m[a]) - int'(d[a]), -512, 511);
        tot[a] = (e >>> 1) + (e >>> 3) + clamp(e - hist[a][0], -64, 63) * 7;
        if (vld) begin
          hist[a].push_back(e);
          void'(hist[a].pop_front());
        end
      end
      b = 704 + int'(thrst);
      ex[0] = clamp(b - tot[0] - tot[2], 0, 2047);
      ex[1] = clamp(b + tot[0] - tot[2], 0, 2047);
      ex[2] = clamp(b - tot[1] + tot[2], 0, 2047);
      ex[3] = clamp(b + tot[1] + tot[2], 0, 2047);
      if (cal) ex = '{432, 432, 432, 432};
    end
    @(posedge clk);
    #1;
    chk("frnt", frnt, ex[0]);
    chk("bck", bck, ex[1]);
    chk("lft", lft, ex[2]);
    chk("rght", rght, ex[3]);
  endtask

  task automatic zero_in();
    for (int a = 0; a < 3; a++) begin
      m[a] = '0;
      d[a] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply();
    rst = 1'b0;
  endtask

  initial begin
    zero_in();
    #1;
    rst = 1'b1;
    repeat (2) begin
      for (int a = 0; a < 3; a++) begin
        m[a] = rnd_ang();
        d[a] = rnd_ang();
      end
      thrst = 9'($urandom);
      vld = 1'($urandom);
      cal = 1'($urandom);
      apply();
    end
    rst = 1'b0;
    cal = 1'b1;
    vld = 1'b1;
    apply();
    chk("cal_const", bck, 432);

    cal = 1'b0;
    do_reset();
    zero_in();
    thrst = 9'd100;
    vld = 1'b1;
    apply();
    chk("zero_err_const", rght, 804);

    do_reset();
    zero_in();
    m[0] = 16'sd64;
    thrst = '0;
    apply();
    chk("step_frnt", frnt, 223);
    chk("step_bck", bck, 1185);
    chk("step_lft", lft, 704);
    repeat (14) apply();
    chk("step_end_frnt", frnt, 664);
    chk("step_end_bck", bck, 744);

    do_reset();
    thrst = 9'd511;
    m[0] = 16'sd1000;
    m[2] = -16'sd1000;
    apply();
    chk("sat_bck", bck, 2047);
    chk("sat_frnt", frnt, 1224);
    m[0] = -16'sd1000;
    m[2] = 16'sd1000;
    apply();
    m[0] = 16'sd1000;
    apply();

    do_reset();
    zero_in();
    thrst = '0;
    vld = 1'b0;
    m[0] = 16'sd64;
    repeat (20) apply();
    chk("gate_frnt", frnt, 223);
    thrst = 9'd50;
    apply();
    chk("gate_refresh", bck, 1235);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 60) == 0);
      cal = ($urandom_range(0, 15) == 0);
      vld = 1'($urandom);
      thrst = 9'($urandom);
      for (int a = 0; a < 3; a++) begin
        m[a] = rnd_ang();
        d[a] = rnd_ang();
      end
      apply();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
